// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type and default sizes for the instruction-fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALT
    } fetch_state_t;

    localparam int         DEFAULT_ADDR_W      = 8;
    localparam int         DEFAULT_INST_W      = 8;
    localparam logic [7:0] DEFAULT_HALT_OPCODE = 8'hFF;

    // Width of the optional performance counters.
    localparam int         PERF_CNT_W          = 16;

endpackage

// File: rtl/fetch_perf_ctr.sv
// fetch_perf_ctr: saturating event counter with synchronous clear, used for the
// optional fetch performance counters (FETCH_CTRL_PERF_EN builds only).
module fetch_perf_ctr
    import fetch_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    output logic [PERF_CNT_W-1:0] count_o
);

    // Count enabled cycles, stick at all-ones; clear wins over a coincident event.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            count_o <= '0;
        end else if (enable_i && (count_o != '1)) begin
            count_o <= count_o + PERF_CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer in front of the combinational inst_rom.
// Owns the fetch PC, drives the ROM address and presents each fetched word to
// decode through a one-entry valid/ready register. Handles start, backpressure,
// absolute/relative branches, PC wrap-around and halt-opcode detection.
// Optional macro FETCH_CTRL_PERF_EN adds handshake and stall counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter int                INST_W      = DEFAULT_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [INST_W-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_W-1:0]     start_addr_i,
    output logic [ADDR_W-1:0]     rom_address_o,
    input  logic [INST_W-1:0]     rom_instruction_i,
    input  logic                  branch_i,
    input  logic                  branch_rel_i,
    input  logic [ADDR_W-1:0]     branch_target_i,
    output logic [INST_W-1:0]     inst_o,
    output logic [ADDR_W-1:0]     pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
`ifdef FETCH_CTRL_PERF_EN
    output logic [PERF_CNT_W-1:0] inst_count_o,
    output logic [PERF_CNT_W-1:0] stall_count_o,
`endif
    output logic                  busy_o,
    output logic                  halted_o
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_next;
    logic [ADDR_W-1:0] acc_pc;
    logic [ADDR_W-1:0] acc_pc_next;
    logic [ADDR_W-1:0] pc_next;
    logic [INST_W-1:0] inst_next;
    logic              valid_next;
    logic              handshake;
    logic              load;
    logic              active;

    assign handshake     = valid_o && ready_i;
    assign load          = !valid_o || ready_i;
    assign active        = (state == RUN) || (state == DRAIN);
    assign rom_address_o = fetch_pc;

    // Register state, PC, output slot and status flags; reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            acc_pc   <= '0;
            inst_o   <= '0;
            pc_o     <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            halted_o <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            acc_pc   <= acc_pc_next;
            inst_o   <= inst_next;
            pc_o     <= pc_next;
            valid_o  <= valid_next;
            busy_o   <= (state_next == RUN) || (state_next == DRAIN);
            halted_o <= (state_next == HALT);
        end
    end

    // Next-state and datapath decode; a branch beats any load, and the relative
    // base already includes an instruction accepted in the same cycle.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        acc_pc_next   = acc_pc;
        inst_next     = inst_o;
        pc_next       = pc_o;
        valid_next    = valid_o;

        if (handshake) begin
            acc_pc_next = pc_o;
        end

        if (active && branch_i) begin
            valid_next    = 1'b0;
            fetch_pc_next = branch_rel_i ? (acc_pc_next + branch_target_i) : branch_target_i;
            state_next    = RUN;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_i) begin
                        fetch_pc_next = start_addr_i;
                        state_next    = RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        inst_next     = rom_instruction_i;
                        pc_next       = fetch_pc;
                        valid_next    = 1'b1;
                        fetch_pc_next = fetch_pc + ADDR_W'(1);
                        if (rom_instruction_i == HALT_OPCODE) begin
                            state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        valid_next = 1'b0;
                        state_next = HALT;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic start_accepted;
    logic stall_cycle;

    assign start_accepted = start_i && ((state == IDLE) || (state == HALT));
    assign stall_cycle    = valid_o && !ready_i;

    fetch_perf_ctr u_inst_ctr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (start_accepted),
        .enable_i (handshake),
        .count_o  (inst_count_o)
    );

    fetch_perf_ctr u_stall_ctr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (start_accepted),
        .enable_i (stall_cycle),
        .count_o  (stall_count_o)
    );
`else
    // Counters compiled out; fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl. A transaction-level model
// of the fetch sequencer is compared with the DUT every cycle, directed
// scenarios pin the model with literal values, then randomized traffic runs.
// Counter checks are included when FETCH_CTRL_PERF_EN is defined.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic        branch;
    logic        branch_rel;
    logic [7:0]  branch_target;
    logic        ready;
    logic [7:0]  rom_address;
    logic [7:0]  rom_instruction;
    logic [7:0]  inst;
    logic [7:0]  pc;
    logic        valid;
    logic        busy;
    logic        halted;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] inst_count;
    logic [15:0] stall_count;
`endif

    int assertions = 0;
    int failures   = 0;

    // Model: what decode must see, described as a presented slot plus a run mode.
    logic        m_valid     = 1'b0;
    logic [7:0]  m_inst      = 8'h00;
    logic [7:0]  m_pc        = 8'h00;
    logic [7:0]  m_next      = 8'h00;
    logic [7:0]  m_last_acc  = 8'h00;
    logic        m_active    = 1'b0;
    logic        m_draining  = 1'b0;
    logic        m_halted    = 1'b0;
    logic [15:0] m_inst_cnt  = 16'h0000;
    logic [15:0] m_stall_cnt = 16'h0000;

    always #5 clk = ~clk;

    // Behavioural ROM: each word equals its address, except a halt word at 0x05.
    function automatic logic [7:0] rom_word(input logic [7:0] a);
        return (a == 8'h05) ? 8'hFF : a;
    endfunction

    assign rom_instruction = rom_word(rom_address);

    fetch_ctrl dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .start_addr_i      (start_addr),
        .rom_address_o     (rom_address),
        .rom_instruction_i (rom_instruction),
        .branch_i          (branch),
        .branch_rel_i      (branch_rel),
        .branch_target_i   (branch_target),
        .inst_o            (inst),
        .pc_o              (pc),
        .valid_o           (valid),
        .ready_i           (ready),
`ifdef FETCH_CTRL_PERF_EN
        .inst_count_o      (inst_count),
        .stall_count_o     (stall_count),
`endif
        .busy_o            (busy),
        .halted_o          (halted)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at a falling edge and return at the next one.
    task automatic applyStimulus(input logic rst, input logic st, input logic [7:0] sa,
                                 input logic br, input logic rel, input logic [7:0] tgt,
                                 input logic rdy);
        reset         = rst;
        start         = st;
        start_addr    = sa;
        branch        = br;
        branch_rel    = rel;
        branch_target = tgt;
        ready         = rdy;
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic rdy);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic stepModel();
        logic hs;
        logic stalled;
        hs      = m_valid && ready;
        stalled = m_valid && !ready;
        if (reset) begin
            m_valid     = 1'b0;
            m_inst      = 8'h00;
            m_pc        = 8'h00;
            m_next      = 8'h00;
            m_last_acc  = 8'h00;
            m_active    = 1'b0;
            m_draining  = 1'b0;
            m_halted    = 1'b0;
            m_inst_cnt  = 16'h0000;
            m_stall_cnt = 16'h0000;
            return;
        end
        if (hs) begin
            m_last_acc = m_pc;
            if (m_inst_cnt != 16'hFFFF) m_inst_cnt++;
        end
        if (stalled && (m_stall_cnt != 16'hFFFF)) m_stall_cnt++;
        if (m_active && branch) begin
            m_valid    = 1'b0;
            m_draining = 1'b0;
            m_next     = branch_rel ? 8'(m_last_acc + branch_target) : branch_target;
        end else if (!m_active) begin
            if (start) begin
                m_next      = start_addr;
                m_active    = 1'b1;
                m_halted    = 1'b0;
                m_inst_cnt  = 16'h0000;
                m_stall_cnt = 16'h0000;
            end
        end else if (m_draining) begin
            if (hs) begin
                m_valid    = 1'b0;
                m_active   = 1'b0;
                m_draining = 1'b0;
                m_halted   = 1'b1;
            end
        end else if (!m_valid || ready) begin
            m_pc    = m_next;
            m_inst  = rom_word(m_next);
            m_valid = 1'b1;
            m_next  = m_next + 8'd1;
            if (m_inst == 8'hFF) m_draining = 1'b1;
        end
    endtask

    // Advance the model on every rising edge from the inputs the DUT samples.
    initial begin
        forever begin
            @(posedge clk);
            stepModel();
        end
    end

    // Compare every DUT output with the model shortly after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            checkOutput("valid_o", 16'(valid), 16'(m_valid));
            checkOutput("inst_o", 16'(inst), 16'(m_inst));
            checkOutput("pc_o", 16'(pc), 16'(m_pc));
            checkOutput("rom_address_o", 16'(rom_address), 16'(m_next));
            checkOutput("busy_o", 16'(busy), 16'(m_active));
            checkOutput("halted_o", 16'(halted), 16'(m_halted));
`ifdef FETCH_CTRL_PERF_EN
            checkOutput("inst_count_o", inst_count, m_inst_cnt);
            checkOutput("stall_count_o", stall_count, m_stall_cnt);
`endif
        end
    end

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        // Reset state, and a branch in IDLE is ignored.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("reset valid", 16'(valid), 16'h0);
        checkOutput("reset pc", 16'(pc), 16'h0);
        checkOutput("reset inst", 16'(inst), 16'h0);
        checkOutput("reset busy", 16'(busy), 16'h0);
        checkOutput("reset halted", 16'(halted), 16'h0);
        checkOutput("reset rom_address", 16'(rom_address), 16'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1);
        checkOutput("idle branch ignored", 16'(rom_address), 16'h0);

        // Start at 0x00 with ready high: two-cycle latency then one per cycle.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("start valid low", 16'(valid), 16'h0);
        checkOutput("start busy", 16'(busy), 16'h1);
        idleCycle(1'b1);
        checkOutput("first valid", 16'(valid), 16'h1);
        checkOutput("first pc", 16'(pc), 16'h0);
        for (int i = 1; i < 5; i++) begin
            idleCycle(1'b1);
            checkOutput("stream pc", 16'(pc), 16'(i));
            checkOutput("stream inst", 16'(inst), 16'(i));
        end

        // Backpressure while 0x02 is presented.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        checkOutput("pre-stall pc", 16'(pc), 16'h02);
        for (int i = 0; i < 3; i++) begin
            idleCycle(1'b0);
            checkOutput("stall pc", 16'(pc), 16'h02);
            checkOutput("stall inst", 16'(inst), 16'h02);
            checkOutput("stall rom_address", 16'(rom_address), 16'h03);
        end
        idleCycle(1'b1);
        checkOutput("post-stall pc", 16'(pc), 16'h03);
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("stall count", stall_count, 16'd3);
        checkOutput("inst count", inst_count, 16'd3);
`endif

        // Halt opcode at 0x05, then restart from HALT at 0x10.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) idleCycle(1'b1);
        checkOutput("halt word pc", 16'(pc), 16'h05);
        checkOutput("halt word inst", 16'(inst), 16'hFF);
        idleCycle(1'b1);
        checkOutput("halted valid", 16'(valid), 16'h0);
        checkOutput("halted flag", 16'(halted), 16'h1);
        checkOutput("halted busy", 16'(busy), 16'h0);
        checkOutput("halted rom_address", 16'(rom_address), 16'h06);
        idleCycle(1'b1);
        checkOutput("halted rom_address hold", 16'(rom_address), 16'h06);
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("restart halted clear", 16'(halted), 16'h0);
        idleCycle(1'b1);
        checkOutput("restart pc", 16'(pc), 16'h10);

        // Absolute branch flushes an unaccepted 0x02.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h40, 1'b0);
        checkOutput("abs branch flush", 16'(valid), 16'h0);
        idleCycle(1'b1);
        checkOutput("abs branch pc", 16'(pc), 16'h40);
        checkOutput("abs branch inst", 16'(inst), 16'h40);

        // Relative branch -4 in the cycle 0x08 is accepted.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h06, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        checkOutput("rel base pc", 16'(pc), 16'h08);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFC, 1'b1);
        checkOutput("rel branch flush", 16'(valid), 16'h0);
        idleCycle(1'b1);
        checkOutput("rel branch pc", 16'(pc), 16'h04);

        // PC wrap from 0xFF to 0x00 (0xFF is also the halt word here).
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b1);
        idleCycle(1'b1);
        checkOutput("wrap pc FE", 16'(pc), 16'hFE);
        idleCycle(1'b1);
        checkOutput("wrap pc FF", 16'(pc), 16'hFF);
        checkOutput("wrap rom_address", 16'(rom_address), 16'h00);

        // Reset mid-RUN overrides a coincident start; start needed to resume.
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        applyStimulus(1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("midrun reset valid", 16'(valid), 16'h0);
        checkOutput("midrun reset pc", 16'(pc), 16'h0);
        checkOutput("midrun reset busy", 16'(busy), 16'h0);
        checkOutput("midrun reset rom_address", 16'(rom_address), 16'h0);
        idleCycle(1'b1);
        checkOutput("no start stays idle", 16'(busy), 16'h0);
        applyStimulus(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b1);
        idleCycle(1'b1);
        checkOutput("resume pc", 16'(pc), 16'h20);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) == 0), 8'($urandom),
                          ($urandom_range(9) == 0), 1'($urandom), 8'($urandom),
                          ($urandom_range(9) < 7));
        end
        idleCycle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
